seq_multiplier: RTL

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier_pkg.sv | 12 +
 rtl/seq_multiplier.sv | 103 ++++++++++
 2 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential add-shift multiplier.
package seq_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Iterative signed/unsigned multiplier: one add-shift step per clock on operand
// magnitudes, with a two's-complement fix-up applied when the result is written.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [PW-1:0]    acc_q, acc_d, prod_d;
  logic [WIDTH-1:0] mcand_q, mplier_q;
  logic [WIDTH-1:0] mag_a_d, mag_b_d;
  logic             neg_q, neg_d;
  logic             ready_q, done_q;
  logic [WIDTH-1:0] lo_q, hi_q;

  // Magnitudes of -2^(WIDTH-1) are 2^(WIDTH-1), which still fits an unsigned WIDTH-bit value.
  always_comb begin
    mag_a_d = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    mag_b_d = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    neg_d   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);

    // NOTE: default first so every path assigns acc_d and no latch is inferred.
    acc_d = acc_q;
    if (mplier_q[cnt_q]) begin
      acc_d = acc_q + ({{WIDTH{1'b0}}, mcand_q} << cnt_q);
    end
    prod_d = neg_q ? -acc_d : acc_d;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= mag_a_d;
            mplier_q <= mag_b_d;
            neg_q    <= neg_d;
            acc_q    <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            lo_q    <= prod_d[WIDTH-1:0];
            hi_q    <= prod_d[PW-1:WIDTH];
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign result_lo = lo_q;
  assign result_hi = hi_q;

endmodule
